// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM state type and default widths for the audio sample feeder.
package audio_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW} state_e;
   localparam int AUDIO_BITS_DEF = 12;
   localparam int UNDERRUN_W = 16;
endpackage

// File: rtl/audio_sample_feeder_if.sv
// audio_sample_feeder_if: producer/DAC bundle; underrun ports exist only with AUDIO_FEEDER_UNDERRUN_EN.
interface audio_sample_feeder_if import audio_pkg::*; #(
   parameter int AUDIO_BITS = AUDIO_BITS_DEF,
   parameter int DEPTH_LOG2 = 4
);
   logic                    in_valid;
   logic [2*AUDIO_BITS-1:0] in_sample;
   logic                    in_ready;
   logic                    dac_ready;
   logic                    dac_wreq;
   logic [2*AUDIO_BITS-1:0] dac_sample;
   logic [DEPTH_LOG2:0]     level;
`ifdef AUDIO_FEEDER_UNDERRUN_EN
   logic                    underrun_clr;
   logic [UNDERRUN_W-1:0]   underrun_cnt;
   modport master (output in_valid, in_sample, dac_ready, underrun_clr,
                   input in_ready, dac_wreq, dac_sample, level, underrun_cnt);
   modport slave (input in_valid, in_sample, dac_ready, underrun_clr,
                  output in_ready, dac_wreq, dac_sample, level, underrun_cnt);
`else
   modport master (output in_valid, in_sample, dac_ready,
                   input in_ready, dac_wreq, dac_sample, level);
   modport slave (input in_valid, in_sample, dac_ready,
                  output in_ready, dac_wreq, dac_sample, level);
`endif
endinterface

// File: rtl/audio_fifo_sync.sv
// audio_fifo_sync: synchronous FIFO, no fall-through; push while full and pop while empty are ignored.
module audio_fifo_sync #(
   parameter int WIDTH = 24,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  aclr_,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  do_push, do_pop;
   assign full_o  = level_q == (DEPTH_LOG2+1)'(DEPTH);
   assign empty_o = level_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;
   always_ff @(posedge clk) begin
      if (!aclr_) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= do_push ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
         rptr_q  <= do_pop ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
         level_q <= level_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: FIFO-backed DAC feeder issuing one wreq per dac_ready window.
// Optional starvation counter enabled by AUDIO_FEEDER_UNDERRUN_EN.
module audio_sample_feeder import audio_pkg::*; #(
   parameter int AUDIO_BITS = AUDIO_BITS_DEF,
   parameter int DEPTH_LOG2 = 4
) (
   input logic                  clk,
   input logic                  aclr_,
   audio_sample_feeder_if.slave bus
);
   state_e                  state_q, state_d;
   logic                    pop, wreq_d, wreq_q, empty, full;
   logic [2*AUDIO_BITS-1:0] head, sample_d, sample_q;
   logic [DEPTH_LOG2:0]     level;
   audio_fifo_sync #(.WIDTH(2*AUDIO_BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .aclr_   (aclr_),
      .push_i  (bus.in_valid),
      .pop_i   (pop),
      .wdata_i (bus.in_sample),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );
   assign bus.in_ready   = !full;
   assign bus.level      = level;
   assign bus.dac_wreq   = wreq_q;
   assign bus.dac_sample = sample_q;
   always_ff @(posedge clk) begin
      if (!aclr_) begin
         state_q  <= IDLE;
         wreq_q   <= 1'b0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         wreq_q   <= wreq_d;
         sample_q <= sample_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE)  ? ((bus.dac_ready && !empty) ? ISSUE : IDLE) :
                (state_q == ISSUE) ? WAIT_LOW :
                (bus.dac_ready ? WAIT_LOW : IDLE);
   end
   always_comb begin
      pop      = (state_q == IDLE) && bus.dac_ready && !empty;
      wreq_d   = pop;
      sample_d = pop ? head : sample_q;
   end
`ifdef AUDIO_FEEDER_UNDERRUN_EN
   logic                  armed_q, armed_d, starve;
   logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;
   // One count per starvation episode: armed by a wreq, disarmed by the count.
   always_comb begin
      starve  = (state_q == IDLE) && bus.dac_ready && empty && armed_q;
      armed_d = pop ? 1'b1 : (starve ? 1'b0 : armed_q);
      ucnt_d  = bus.underrun_clr ? '0 :
                (starve && ucnt_q != '1) ? ucnt_q + UNDERRUN_W'(1) : ucnt_q;
   end
   always_ff @(posedge clk) begin
      if (!aclr_) begin
         armed_q <= 1'b0;
         ucnt_q  <= '0;
      end else begin
         armed_q <= armed_d;
         ucnt_q  <= ucnt_d;
      end
   end
   assign bus.underrun_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder: scoreboard bench for audio_sample_feeder (underrun test with AUDIO_FEEDER_UNDERRUN_EN).
module tb_audio_sample_feeder;
   localparam int AB = 12;
   localparam int DL = 4;
   localparam int DEPTH = 1 << DL;
   logic clk = 1'b0;
   logic aclr_ = 1'b0;
   int checks = 0;
   int errors = 0;
   int wreq_cnt = 0;
   logic [2*AB-1:0] exp_q[$];
   audio_sample_feeder_if #(.AUDIO_BITS(AB), .DEPTH_LOG2(DL)) bus();
   audio_sample_feeder #(.AUDIO_BITS(AB), .DEPTH_LOG2(DL)) dut (.clk(clk), .aclr_(aclr_), .bus(bus));
   always #5 clk = ~clk;

   // Model the accepted push before the edge, then pop the scoreboard on each observed wreq.
   task automatic tick();
      logic [2*AB-1:0] e;
      if (!aclr_) exp_q.delete();
      else if (bus.in_valid && exp_q.size() < DEPTH) exp_q.push_back(bus.in_sample);
      @(posedge clk);
      #1;
      if (bus.dac_wreq === 1'b1) begin
         wreq_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_wreq got %h expected no wreq", bus.dac_sample);
         end else begin
            e = exp_q.pop_front();
            if (bus.dac_sample !== e) begin
               errors++;
               $display("FAIL sb_order got %h expected %h", bus.dac_sample, e);
            end
         end
      end
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sample = (2*AB)'($urandom);
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         bus.dac_ready = 1'b1;
         tick();
         bus.dac_ready = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic do_reset();
      aclr_ = 1'b0;
      tick();
      tick();
      aclr_ = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", bus.level); end
      if (bus.dac_wreq !== 1'b0) begin errors++; $display("FAIL reset_wreq got %b expected 0", bus.dac_wreq); end
      if (bus.dac_sample !== 24'h0) begin errors++; $display("FAIL reset_sample got %h expected 0", bus.dac_sample); end
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
`ifdef AUDIO_FEEDER_UNDERRUN_EN
      checks++;
      if (bus.underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt got %0d expected 0", bus.underrun_cnt); end
`endif
   endtask

   task automatic test_single();
      int w0;
      w0 = wreq_cnt;
      bus.in_valid = 1'b1;
      bus.in_sample = 24'hABC123;
      bus.dac_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks += 2;
      if (bus.level !== 5'd1) begin errors++; $display("FAIL single_level_push got %0d expected 1", bus.level); end
      if (bus.dac_wreq !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got %b expected 0", bus.dac_wreq); end
      tick();
      checks += 3;
      if (bus.dac_wreq !== 1'b1) begin errors++; $display("FAIL single_wreq got %b expected 1", bus.dac_wreq); end
      if (bus.dac_sample !== 24'hABC123) begin errors++; $display("FAIL single_sample got %h expected abc123", bus.dac_sample); end
      if (bus.level !== 5'd0) begin errors++; $display("FAIL single_level_pop got %0d expected 0", bus.level); end
      tick();
      checks++;
      if (bus.dac_wreq !== 1'b0) begin errors++; $display("FAIL single_wreq_width got %b expected 0", bus.dac_wreq); end
      repeat (5) tick();
      checks += 2;
      if (wreq_cnt - w0 != 1) begin errors++; $display("FAIL single_pulses got %0d expected 1", wreq_cnt - w0); end
      if (bus.dac_sample !== 24'hABC123) begin errors++; $display("FAIL single_hold got %h expected abc123", bus.dac_sample); end
      bus.dac_ready = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_full_and_drain();
      int w0;
      logic [2*AB-1:0] first;
      w0 = wreq_cnt;
      bus.dac_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_sample = 24'h13579B;
      first = bus.in_sample;
      tick();
      push_words(DEPTH - 1);
      checks += 2;
      if (bus.level !== 5'd16) begin errors++; $display("FAIL full_level got %0d expected 16", bus.level); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b expected 0", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_sample = 24'hDEAD00;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.level !== 5'd16) begin errors++; $display("FAIL full_drop_level got %0d expected 16", bus.level); end
      bus.in_valid = 1'b1;
      bus.in_sample = 24'h5A5A5A;
      bus.dac_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.dac_ready = 1'b0;
      checks += 3;
      if (bus.level !== 5'd15) begin errors++; $display("FAIL full_pushpop_level got %0d expected 15", bus.level); end
      if (bus.dac_wreq !== 1'b1) begin errors++; $display("FAIL full_pushpop_wreq got %b expected 1", bus.dac_wreq); end
      if (bus.dac_sample !== first) begin errors++; $display("FAIL full_pushpop_sample got %h expected %h", bus.dac_sample, first); end
      tick();
      tick();
      drain(DEPTH - 1);
      drain(2);
      checks += 2;
      if (wreq_cnt - w0 != DEPTH) begin errors++; $display("FAIL drain_count got %0d expected 16", wreq_cnt - w0); end
      if (bus.level !== 5'd0) begin errors++; $display("FAIL drain_level got %0d expected 0", bus.level); end
   endtask

   task automatic test_one_per_window();
      int w0;
      w0 = wreq_cnt;
      push_words(3);
      bus.dac_ready = 1'b1;
      repeat (10) tick();
      checks += 2;
      if (wreq_cnt - w0 != 1) begin errors++; $display("FAIL window_one got %0d expected 1", wreq_cnt - w0); end
      if (bus.level !== 5'd2) begin errors++; $display("FAIL window_level got %0d expected 2", bus.level); end
      bus.dac_ready = 1'b0;
      tick();
      tick();
      bus.dac_ready = 1'b1;
      tick();
      bus.dac_ready = 1'b0;
      checks++;
      if (wreq_cnt - w0 != 2) begin errors++; $display("FAIL window_second got %0d expected 2", wreq_cnt - w0); end
      tick();
      tick();
      drain(1);
      checks++;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL window_drain_level got %0d expected 0", bus.level); end
   endtask

   task automatic test_reset_mid();
      int w0;
      push_words(6);
      bus.dac_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.level !== 5'd5) begin errors++; $display("FAIL midrst_pre_level got %0d expected 5", bus.level); end
      aclr_ = 1'b0;
      tick();
      aclr_ = 1'b1;
      checks += 3;
      if (bus.level !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d expected 0", bus.level); end
      if (bus.dac_wreq !== 1'b0) begin errors++; $display("FAIL midrst_wreq got %b expected 0", bus.dac_wreq); end
      if (bus.dac_sample !== 24'h0) begin errors++; $display("FAIL midrst_sample got %h expected 0", bus.dac_sample); end
      w0 = wreq_cnt;
      bus.dac_ready = 1'b0;
      tick();
      drain(3);
      checks++;
      if (wreq_cnt != w0) begin errors++; $display("FAIL midrst_no_wreq got %0d expected 0", wreq_cnt - w0); end
   endtask

`ifdef AUDIO_FEEDER_UNDERRUN_EN
   task automatic test_underrun();
      do_reset();
      push_words(1);
      bus.dac_ready = 1'b1;
      tick();
      tick();
      bus.dac_ready = 1'b0;
      tick();
      bus.dac_ready = 1'b1;
      repeat (50) tick();
      bus.dac_ready = 1'b0;
      checks++;
      if (bus.underrun_cnt !== 16'd1) begin errors++; $display("FAIL underrun_cnt got %0d expected 1", bus.underrun_cnt); end
      bus.underrun_clr = 1'b1;
      tick();
      bus.underrun_clr = 1'b0;
      checks++;
      if (bus.underrun_cnt !== 16'd0) begin errors++; $display("FAIL underrun_clr got %0d expected 0", bus.underrun_cnt); end
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sample = '0;
      bus.dac_ready = 1'b0;
`ifdef AUDIO_FEEDER_UNDERRUN_EN
      bus.underrun_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_full_and_drain();
      test_one_per_window();
      test_reset_mid();
`ifdef AUDIO_FEEDER_UNDERRUN_EN
      test_underrun();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 SHALL have parameter AUDIO_BITS, default 12, bits per channel; a stereo word is 2*AUDIO_BITS with left in the upper half.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 stereo words.
REQ-003 clk  in  1  single clock; connected to the audio DAC clock (clk_audio).
REQ-004 aclr_  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  producer offers in_sample this cycle.
REQ-006 in_sample  in  2*AUDIO_BITS  stereo word from producer.
REQ-007 in_ready  out  1  FIFO can accept a word (= not full).
REQ-008 dac_ready  in  1  downstream DAC ready for next sample.
REQ-009 dac_wreq  out  1  registered single-cycle write request to DAC.
REQ-010 dac_sample  out  2*AUDIO_BITS  registered word; valid with dac_wreq and held until next wreq.
REQ-011 level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-012 underrun_clr  in  1  clears underrun_cnt (only with AUDIO_FEEDER_UNDERRUN_EN).
REQ-013 underrun_cnt  out  16  starvation episode count (only with AUDIO_FEEDER_UNDERRUN_EN).

Function
REQ-014 Push SHALL occur on a clk edge when in_valid && in_ready; in_valid while full SHALL be ignored, with no change to FIFO contents.
REQ-015 FSM SHALL have states IDLE, ISSUE and WAIT_LOW.
REQ-016 IDLE -> ISSUE on an edge with dac_ready=1 and FIFO non-empty; on that edge the head word is popped, dac_sample is loaded from it, and dac_wreq is set to 1.
REQ-017 ISSUE -> WAIT_LOW unconditionally on the next edge; dac_wreq returns to 0, so it is high for exactly one cycle.
REQ-018 WAIT_LOW -> IDLE on the first edge with dac_ready=0; the FSM SHALL remain in WAIT_LOW while dac_ready=1, which guarantees one wreq per DAC ready window.
REQ-019 Latency SHALL be one cycle from dac_ready=1 with a non-empty FIFO (sampled in IDLE) to dac_wreq=1.
REQ-020 Push and pop on the same edge SHALL both succeed; level is unchanged; push when full is blocked even if a pop occurs on that edge.
REQ-021 Pop from an empty FIFO SHALL never occur; in IDLE with the FIFO empty the FSM SHALL stay in IDLE and dac_sample SHALL hold its value.
REQ-022 A word pushed into an empty FIFO SHALL be poppable no earlier than the next edge (no fall-through).
REQ-023 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth; level SHALL range 0..2**DEPTH_LOG2.
REQ-024 Output order SHALL equal input order, bit-exact, with no arithmetic on samples.

Reset
REQ-025 On an edge with aclr_=0: state=IDLE, pointers=0, level=0, dac_wreq=0, dac_sample=0, underrun_cnt=0, armed flag=0.
REQ-026 Reset asserted mid-operation (including in ISSUE or WAIT_LOW) SHALL discard FIFO contents and abort the pending handshake with no further dac_wreq.
REQ-027 in_ready SHALL be 1 from the first edge after reset release.

Configuration
REQ-028 Macro AUDIO_FEEDER_UNDERRUN_EN defined: an armed flag SHALL set on each dac_wreq; on an edge where state=IDLE, dac_ready=1, the FIFO is empty and armed=1, underrun_cnt SHALL increment (saturating at 0xFFFF) and armed SHALL clear.
REQ-029 With AUDIO_FEEDER_UNDERRUN_EN defined, underrun_clr=1 SHALL zero underrun_cnt, taking priority over an increment on the same edge.
REQ-030 Macro undefined: underrun_clr and underrun_cnt ports, the armed flag and the counter logic SHALL be absent.

Structure
REQ-031 Shared package audio_pkg SHALL hold the FSM state typedef (IDLE/ISSUE/WAIT_LOW), the default AUDIO_BITS constant (12) and the underrun counter width constant (16).
REQ-032 The FIFO storage and pointers SHALL be a sub-module audio_fifo_sync (push, pop, data, full, empty, level); the FSM and the optional counter live in audio_sample_feeder.

Verification
REQ-033 Reset, push 0xABC123, hold dac_ready=1 -> exactly one dac_wreq pulse with dac_sample=0xABC123 one cycle after the push becomes visible; level returns to 0.
REQ-034 Push 16 words with dac_ready=0 -> level=16, in_ready=0; a 17th in_valid is dropped; drain 16 words in order with no 17th.
REQ-035 dac_ready held high for 10 cycles with 3 words queued -> exactly one dac_wreq until dac_ready drops and rises again.
REQ-036 Full FIFO with simultaneous in_valid and pop edge -> push rejected, level=15, popped word correct.
REQ-037 aclr_=0 for one edge while in WAIT_LOW with 5 words queued -> level=0, dac_wreq=0, dac_sample=0, no wreq after release.
REQ-038 With AUDIO_FEEDER_UNDERRUN_EN: issue one word, then dac_ready high on an empty FIFO for 50 cycles -> underrun_cnt=1 (not 50); underrun_clr -> 0.
